// File: rtl/compare_scheduler.sv
// Round-robin front end for a shared iterative comparator: grants one
// requester at a time, holds its operands, and returns the result or a timeout.
module compare_scheduler #(
    parameter int iW      = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 40
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [NREQ-1:0]    iReq,
    input  logic [NREQ*iW-1:0] iDataX,
    input  logic [NREQ*iW-1:0] iDataY,
    output logic               oCmpEnable,
    output logic [iW-1:0]      oCmpX,
    output logic [iW-1:0]      oCmpY,
    input  logic [1:0]         iCmpMode,
    output logic [NREQ-1:0]    oAck,
    output logic [1:0]         oResult,
    output logic               oErr,
    output logic [1:0]         oGrant,
    output logic               oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [1:0] last;
    logic [1:0] pick;
    logic       found;
    logic       any_req;
    logic       mode_valid;
    logic       timed_out;

    assign any_req    = |iReq;
    assign mode_valid = (iCmpMode != 2'b00);
    assign timed_out  = (cnt == 8'(TIMEOUT));

    // Search starts just after the last grant, so the last winner ranks lowest.
    always_comb begin
        found = 1'b0;
        pick  = last;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && iReq[last + 2'(i)]) begin
                found = 1'b1;
                pick  = last + 2'(i);
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any_req) state_nxt = RUN;
            RUN:  if (mode_valid || timed_out) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oCmpEnable <= 1'b0;
            oCmpX      <= '0;
            oCmpY      <= '0;
            oAck       <= '0;
            oResult    <= 2'b00;
            oErr       <= 1'b0;
            oGrant     <= 2'd0;
            oBusy      <= 1'b0;
            cnt        <= '0;
            last       <= 2'(NREQ - 1);
        end else begin
            oAck <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        last       <= pick;
                        oGrant     <= pick;
                        oCmpX      <= iDataX[pick*iW +: iW];
                        oCmpY      <= iDataY[pick*iW +: iW];
                        oCmpEnable <= 1'b1;
                        oBusy      <= 1'b1;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 8'd1;
                    // A valid mode wins over a timeout landing on the same edge.
                    if (mode_valid) begin
                        oResult    <= iCmpMode;
                        oErr       <= 1'b0;
                        oCmpEnable <= 1'b0;
                        oAck       <= NREQ'(1) << oGrant;
                    end else if (timed_out) begin
                        oResult    <= 2'b00;
                        oErr       <= 1'b1;
                        oCmpEnable <= 1'b0;
                        oAck       <= NREQ'(1) << oGrant;
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                end
                default: begin
                    oBusy      <= 1'b0;
                    oCmpEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_scheduler.sv
// Directed and randomized jobs against a round-robin / comparator model.
module tb_compare_scheduler;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 40;

    logic           iClk = 1'b0;
    logic           iRst = 1'b1;
    logic [N-1:0]   iReq = '0;
    logic [N*W-1:0] iDataX;
    logic [N*W-1:0] iDataY;
    logic           oCmpEnable;
    logic [W-1:0]   oCmpX;
    logic [W-1:0]   oCmpY;
    logic [1:0]     iCmpMode = 2'b00;
    logic [N-1:0]   oAck;
    logic [1:0]     oResult;
    logic           oErr;
    logic [1:0]     oGrant;
    logic           oBusy;

    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];

    int total = 0;
    int bad   = 0;
    int ptr   = N - 1;
    int ecount = 0;
    int cmp_lat = 32;
    bit cmp_tie0 = 1'b0;

    compare_scheduler #(.iW(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq),
        .iDataX(iDataX), .iDataY(iDataY),
        .oCmpEnable(oCmpEnable), .oCmpX(oCmpX), .oCmpY(oCmpY),
        .iCmpMode(iCmpMode), .oAck(oAck), .oResult(oResult),
        .oErr(oErr), .oGrant(oGrant), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    always_comb begin
        iDataX = '0;
        iDataY = '0;
        for (int i = 0; i < N; i++) begin
            iDataX[i*W +: W] = xs[i];
            iDataY[i*W +: W] = ys[i];
        end
    end

    function automatic logic [1:0] cmpf(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y) return 2'b10;
        if (x > y) return 2'b01;
        return 2'b11;
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return p;
    endfunction

    // Comparator: mode appears once cmp_lat enabled edges have passed.
    always @(negedge iClk) begin
        if (!oCmpEnable) begin
            ecount   <= 0;
            iCmpMode <= 2'b00;
        end else begin
            ecount   <= ecount + 1;
            iCmpMode <= (!cmp_tie0 && ecount >= cmp_lat) ? cmpf(oCmpX, oCmpY) : 2'b00;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [N-1:0] req, input int lat, input bit tie0,
                           input bit mutate, input bit drop, input bit noise);
        int n;
        int eg;
        logic [W-1:0] ex;
        logic [W-1:0] ey;
        logic [1:0] er;
        bit ee;
        int elat;
        bit stable;
        @(negedge iClk);
        check("idle_ack", 64'(oAck), 64'(0));
        check("idle_en", 64'(oCmpEnable), 64'(0));
        check("idle_busy", 64'(oBusy), 64'(0));
        cmp_lat  = lat;
        cmp_tie0 = tie0;
        iReq     = req;
        eg   = rr(req, ptr);
        ptr  = eg;
        ex   = xs[eg];
        ey   = ys[eg];
        ee   = tie0 || (lat > TO);
        er   = ee ? 2'b00 : cmpf(ex, ey);
        elat = ee ? TO + 1 : lat + 1;
        @(negedge iClk);
        check("grant", 64'(oGrant), 64'(eg));
        check("grant_en", 64'(oCmpEnable), 64'(1));
        check("grant_busy", 64'(oBusy), 64'(1));
        check("grant_x", 64'(oCmpX), 64'(ex));
        check("grant_y", 64'(oCmpY), 64'(ey));
        n = 0;
        stable = 1'b1;
        while (oAck == '0 && n < 400) begin
            if (drop && n == 3) iReq = '0;
            if (noise && n == 4) iReq = N'($urandom_range(0, 15));
            if (mutate && n == 5) begin
                xs[eg] = ~xs[eg];
                ys[eg] = ys[eg] ^ 32'h0F0F_0F0F;
            end
            @(negedge iClk);
            n++;
            if (oAck == '0 && (oCmpEnable !== 1'b1 || oBusy !== 1'b1 ||
                oCmpX !== ex || oCmpY !== ey || oGrant !== 2'(eg)))
                stable = 1'b0;
        end
        check("latency", 64'(n), 64'(elat));
        check("ack", 64'(oAck), 64'(1 << eg));
        check("result", 64'(oResult), 64'(er));
        check("err", 64'(oErr), 64'(ee));
        check("done_grant", 64'(oGrant), 64'(eg));
        check("done_en", 64'(oCmpEnable), 64'(0));
        check("done_busy", 64'(oBusy), 64'(1));
        check("run_stable", 64'(stable), 64'(1));
    endtask

    initial begin
        bit quiet;
        for (int i = 0; i < N; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end
        repeat (2) @(negedge iClk);
        check("rst_en", 64'(oCmpEnable), 64'(0));
        check("rst_ack", 64'(oAck), 64'(0));
        check("rst_result", 64'(oResult), 64'(0));
        check("rst_err", 64'(oErr), 64'(0));
        check("rst_busy", 64'(oBusy), 64'(0));
        check("rst_grant", 64'(oGrant), 64'(0));
        check("rst_x", 64'(oCmpX), 64'(0));
        check("rst_y", 64'(oCmpY), 64'(0));
        iRst = 1'b0;

        // All four requesting, X > Y everywhere: expect 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            xs[i] = 32'(100 + i);
            ys[i] = 32'(i);
        end
        for (int k = 0; k < 5; k++) run_job(4'b1111, 32, 0, 0, 0, 0);
        check("rr_wrap_ptr", 64'(ptr), 64'(0));
        iReq = '0;

        xs[0] = 32'd5;
        ys[0] = 32'd9;
        run_job(4'b0001, 32, 0, 0, 0, 0);
        iReq = '0;

        xs[2] = 32'hDEAD_BEEF;
        ys[2] = 32'hDEAD_BEEF;
        run_job(4'b0100, 32, 0, 0, 0, 0);
        iReq = '0;

        run_job(4'b1000, 32, 1, 0, 0, 0);
        iReq = '0;

        xs[1] = 32'd7;
        ys[1] = 32'd3;
        run_job(4'b0010, 32, 0, 1, 0, 0);
        iReq = '0;

        run_job(4'b0100, 20, 0, 0, 1, 0);
        iReq = '0;

        // Reset mid-job: no ack, enable drops at once, pointer back to 3.
        @(negedge iClk);
        iReq = 4'b0010;
        @(negedge iClk);
        repeat (10) @(negedge iClk);
        iReq = '0;
        iRst = 1'b1;
        #1;
        check("mid_rst_en", 64'(oCmpEnable), 64'(0));
        check("mid_rst_busy", 64'(oBusy), 64'(0));
        check("mid_rst_ack", 64'(oAck), 64'(0));
        @(negedge iClk);
        iRst = 1'b0;
        ptr  = N - 1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge iClk);
            if (oAck !== '0 || oBusy !== 1'b0) quiet = 1'b0;
        end
        check("post_rst_quiet", 64'(quiet), 64'(1));
        run_job(4'b1111, 32, 0, 0, 0, 0);
        check("post_rst_first", 64'(ptr), 64'(0));
        iReq = '0;

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = $urandom;
                ys[i] = ($urandom_range(0, 3) == 0) ? xs[i] : $urandom;
            end
            run_job(N'($urandom_range(1, 15)), int'($urandom_range(0, TO + 5)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
            iReq = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compare_scheduler.md
COMPARE_SCHEDULER -- requirements
Module: compare_scheduler

Interface
REQ-001 Parameter iW, default 32, operand width in bits.
REQ-002 Parameter NREQ, fixed at 4, number of requesters.
REQ-003 Parameter TIMEOUT, default 40, legal range 34..255; RUN-cycle limit before abort.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: ports iClk and iRst.
REQ-005 iClk  input  1  rising-edge clock.
REQ-006 iRst  input  1  asynchronous active-high reset.
REQ-007 iReq  input  NREQ  level request per requester.
REQ-008 iDataX  input  NREQ*iW  X operands; requester i at bits [i*iW +: iW].
REQ-009 iDataY  input  NREQ*iW  Y operands; same packing as iDataX.
REQ-010 oCmpEnable  output  1  enable to the iterative comparator.
REQ-011 oCmpX  output  iW  X operand to the comparator.
REQ-012 oCmpY  output  iW  Y operand to the comparator.
REQ-013 iCmpMode  input  2  comparator result: 00 not ready, 10 X<Y, 01 X>Y, 11 equal.
REQ-014 oAck  output  NREQ  one-hot completion pulse per requester.
REQ-015 oResult  output  2  captured mode; valid while oAck is nonzero.
REQ-016 oErr  output  1  timeout flag; valid while oAck is nonzero.
REQ-017 oGrant  output  2  index of the requester in service; valid while oBusy=1 or oAck is nonzero.
REQ-018 oBusy  output  1  high in RUN and DONE.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-020 IDLE: if any iReq bit is high, the block SHALL grant the next requesting index in round-robin order, starting at last-granted+1 mod NREQ.
REQ-021 On grant, the block SHALL latch the granted X into oCmpX and Y into oCmpY, set oGrant, set oCmpEnable=1, clear the cycle counter, and enter RUN.
REQ-022 oCmpX and oCmpY SHALL stay constant from grant until the next grant, whatever iDataX/iDataY do.
REQ-023 RUN: the counter SHALL increment once per cycle, and oCmpEnable SHALL stay 1.
REQ-024 RUN: on the first cycle with iCmpMode != 00, the block SHALL capture iCmpMode into oResult, set oErr=0, and enter DONE at that edge.
REQ-025 RUN: if the counter reaches TIMEOUT with iCmpMode still 00, the block SHALL set oResult=00 and oErr=1 and enter DONE.
REQ-026 DONE: for exactly one cycle, oCmpEnable SHALL be 0, oAck[oGrant] SHALL be 1 and all other oAck bits 0; the next state SHALL be IDLE.
REQ-027 oCmpEnable SHALL be low for at least 2 cycles (DONE plus IDLE) between jobs, so the comparator state clears.
REQ-028 Latency: if the request is sampled at edge E0, oAck SHALL be high in the cycle after edge E33, provided the comparator's mode becomes valid 32 enabled edges after its enable rises.
REQ-029 Requests arriving during RUN or DONE SHALL be ignored until IDLE; dropping iReq during RUN SHALL NOT abort the job, and its ack is still issued.
REQ-030 A requester SHALL deassert iReq in the cycle after its oAck, or it is treated as a new request.
REQ-031 The last-granted pointer SHALL update only on grant.

Reset
REQ-032 iRst SHALL asynchronously force: state IDLE; oCmpEnable=0; oAck=0; oResult=00; oErr=0; oBusy=0; oGrant=0; oCmpX=0; oCmpY=0; counter=0; last-granted pointer=NREQ-1 (requester 0 first).
REQ-033 Reset during RUN SHALL abort the job with no oAck, and the first grant after release SHALL follow REQ-020 using the reset pointer.

Verification
REQ-034 Requester 0 only, X=5, Y=9, comparator model attached -> oAck=0001 in the cycle after E33, oResult=10, oErr=0.
REQ-035 iReq=1111 held continuously, X>Y on all -> grants in order 0,1,2,3,0, each oAck with oResult=01.
REQ-036 X=Y=0xDEADBEEF on requester 2 -> oAck=0100, oResult=11.
REQ-037 iCmpMode tied to 00 -> oAck at TIMEOUT+1 cycles after grant, oResult=00, oErr=1.
REQ-038 iRst pulse at RUN cycle 10 -> no oAck, oCmpEnable=0 immediately, and the next job grants requester 0 first.
REQ-039 Change iDataX of the granted requester during RUN -> oCmpX unchanged and oResult reflects the latched operands.
